// File: rtl/burst_mem_ctrl.sv
// Single-port word memory with ready/valid requests, byte/word/burst access,
// programmable read latency and range/alignment error reporting.
module burst_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter string       MEM_FILE    = "",
    parameter int          READ_LAT    = 1,
    parameter int          MAX_BURST   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic        rd_wr,
    input  logic [1:0]  access_size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic [29:0]   word_off;
    logic          bad, accept, beat_en, beat_rd, beat_byte, cur_rd;
    logic [AW-1:0] beat_idx, cur_idx;
    logic [4:0]    sh;
    logic [2:0]    cnt;
    logic [31:0]   word_q, beat_rdata, wr_word;

    logic [READ_LAT:1]       vld_pipe;
    logic [READ_LAT:1][31:0] dat_pipe;

    always_comb begin
        word_off = 30'((addr - BASE_ADDR) >> 2);
        bad = (addr < BASE_ADDR)
           || ({2'b00, word_off} >= 32'(DEPTH_WORDS))
           || (access_size == 2'd3 && MAX_BURST == 4)
           || (access_size != 2'd0 && addr[1:0] != 2'b00);
    end

    assign accept    = req_valid && req_ready;
    assign beat_en   = !rst && ((accept && !bad) || state == BURST);
    assign beat_idx  = (state == BURST) ? cur_idx : word_off[AW-1:0];
    assign beat_rd   = (state == BURST) ? cur_rd : rd_wr;
    assign beat_byte = (state == IDLE) && (access_size == 2'd0);
    // big-endian lanes: lane 0 lives in bits 31:24
    assign sh        = {~addr[1:0], 3'b000};
    assign word_q    = mem[beat_idx];

    always_comb begin
        beat_rdata = word_q;
        wr_word    = wdata;
        if (beat_byte) begin
            beat_rdata = {24'h0, 8'(word_q >> sh)};
            wr_word    = (word_q & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh);
        end
    end

    always_ff @(posedge clk)
        if (beat_en && !beat_rd) mem[beat_idx] <= wr_word;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept && !bad && access_size[1]) state_nxt = BURST;
            BURST: if (cnt == 3'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !rst;
        busy      = (state == BURST);
    end

    // cnt holds beats still to go after the current BURST cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cur_idx <= '0;
            cur_rd  <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= accept && bad;
            if (state == IDLE && accept && !bad) begin
                cur_idx <= beat_idx + 1'b1;
                cur_rd  <= rd_wr;
                cnt     <= access_size[0] ? 3'd6 : 3'd2;
            end else if (state == BURST) begin
                cur_idx <= cur_idx + 1'b1;
                if (cnt != 3'd0) cnt <= cnt - 1'b1;
            end
        end
    end

    // stages only load on valid so rdata holds its last beat
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe[1] <= beat_en && beat_rd;
            if (beat_en && beat_rd) dat_pipe[1] <= beat_rdata;
            for (int i = 2; i <= READ_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign rdata       = dat_pipe[READ_LAT];
    assign rdata_valid = vld_pipe[READ_LAT];
endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Directed bench: u0 (READ_LAT=1) and u1 (READ_LAT=3) share one stimulus stream.
module tb_burst_mem_ctrl;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clk = 1'b0;
    logic        rst, req_valid, rd_wr;
    logic [31:0] addr, wdata;
    logic [1:0]  access_size;
    logic        rdy0, rv0, busy0, err0, rdy1, rv1, busy1, err1;
    logic [31:0] rdata0, rdata1;

    always #5 clk = ~clk;

    burst_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .MEM_FILE(""), .READ_LAT(1), .MAX_BURST(8)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .addr(addr), .rd_wr(rd_wr),
        .access_size(access_size), .wdata(wdata), .rdata(rdata0), .rdata_valid(rv0), .busy(busy0), .err(err0));

    burst_mem_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(16), .MEM_FILE(""), .READ_LAT(3), .MAX_BURST(8)) u1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .addr(addr), .rd_wr(rd_wr),
        .access_size(access_size), .wdata(wdata), .rdata(rdata1), .rdata_valid(rv1), .busy(busy1), .err(err1));

    typedef struct {
        logic        v;
        logic        rw;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        e_rdy;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[22];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // drive on the falling edge, sample 1ns later (outputs reflect the last rising edge)
    task automatic drive(input logic r, input logic v, input logic rw, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = r; req_valid = v; rd_wr = rw; access_size = sz; addr = a; wdata = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 2'd0, BASE, 32'h0);
    endtask

    initial begin
        //          v  rw sz     addr          wdata          rdy rv rdata          busy err
        tbl[0]  = '{1, 0, 2'd1, BASE,          32'hDEADBEEF, 1, 0, 32'h0,          0, 0};
        tbl[1]  = '{1, 1, 2'd1, BASE,          32'h0,        1, 0, 32'h0,          0, 0};
        tbl[2]  = '{1, 0, 2'd0, BASE + 1,      32'h000000AA, 1, 1, 32'hDEADBEEF,   0, 0};
        tbl[3]  = '{1, 1, 2'd1, BASE,          32'h0,        1, 0, 32'hDEADBEEF,   0, 0};
        tbl[4]  = '{1, 1, 2'd0, BASE + 3,      32'h0,        1, 1, 32'hDEAABEEF,   0, 0};
        tbl[5]  = '{0, 1, 2'd0, BASE,          32'h0,        1, 1, 32'h000000EF,   0, 0};
        tbl[6]  = '{1, 1, 2'd1, 32'h8001_FFFC, 32'h0,        1, 0, 32'h000000EF,   0, 0};
        tbl[7]  = '{1, 1, 2'd1, BASE + 32'h40, 32'h0,        1, 0, 32'h000000EF,   0, 1};
        tbl[8]  = '{1, 1, 2'd1, BASE + 2,      32'h0,        1, 0, 32'h000000EF,   0, 1};
        tbl[9]  = '{0, 1, 2'd0, BASE,          32'h0,        1, 0, 32'h000000EF,   0, 1};
        tbl[10] = '{0, 1, 2'd0, BASE,          32'h0,        1, 0, 32'h000000EF,   0, 0};
        tbl[11] = '{1, 0, 2'd2, BASE + 32'h38, 32'd1,        1, 0, 32'h000000EF,   0, 0};
        tbl[12] = '{1, 1, 2'd1, BASE + 4,      32'd2,        0, 0, 32'h000000EF,   1, 0};
        tbl[13] = '{0, 0, 2'd0, BASE,          32'd3,        0, 0, 32'h000000EF,   1, 0};
        tbl[14] = '{0, 0, 2'd0, BASE,          32'd4,        0, 0, 32'h000000EF,   1, 0};
        tbl[15] = '{0, 1, 2'd0, BASE,          32'h0,        1, 0, 32'h000000EF,   0, 0};
        tbl[16] = '{1, 1, 2'd2, BASE + 32'h38, 32'h0,        1, 0, 32'h000000EF,   0, 0};
        tbl[17] = '{0, 1, 2'd0, BASE,          32'h0,        0, 1, 32'd1,          1, 0};
        tbl[18] = '{0, 1, 2'd0, BASE,          32'h0,        0, 1, 32'd2,          1, 0};
        tbl[19] = '{0, 1, 2'd0, BASE,          32'h0,        0, 1, 32'd3,          1, 0};
        tbl[20] = '{0, 1, 2'd0, BASE,          32'h0,        1, 1, 32'd4,          0, 0};
        tbl[21] = '{0, 1, 2'd0, BASE,          32'h0,        1, 0, 32'd4,          0, 0};

        rst = 1'b1; req_valid = 1'b0; rd_wr = 1'b1; access_size = 2'd0; addr = BASE; wdata = '0;
        repeat (2) drive(1'b1, 1'b0, 1'b1, 2'd0, BASE, 32'h0);
        chk("reset_ready", 32'(rdy0), 32'd0);
        chk("reset_rdata", rdata0, 32'h0);
        chk("reset_rvalid", 32'(rv0), 32'd0);
        chk("reset_busy", 32'(busy0), 32'd0);
        chk("reset_err", 32'(err0), 32'd0);
        chk("reset_rdata_lat3", rdata1, 32'h0);

        for (int i = 0; i < 22; i++) begin
            drive(1'b0, tbl[i].v, tbl[i].rw, tbl[i].sz, tbl[i].a, tbl[i].wd);
            chk($sformatf("vec%0d_ready", i), 32'(rdy0), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_rvalid", i), 32'(rv0), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d_rdata", i), rdata0, tbl[i].e_rd);
            chk($sformatf("vec%0d_busy", i), 32'(busy0), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d_err", i), 32'(err0), 32'(tbl[i].e_err));
        end

        // fill idx 0..7 with 0x100+i using an 8-beat write
        drive(1'b0, 1'b1, 1'b0, 2'd3, BASE, 32'h100);
        for (int k = 1; k < 8; k++) drive(1'b0, 1'b0, 1'b0, 2'd0, BASE, 32'h100 + 32'(k));
        idle();

        // 8-beat read through the 3-cycle pipeline
        for (int k = 0; k < 12; k++) begin
            if (k == 0) drive(1'b0, 1'b1, 1'b1, 2'd3, BASE, 32'h0);
            else idle();
            chk($sformatf("lat3_busy_c%0d", k), 32'(busy1), 32'(k >= 1 && k <= 7));
            chk($sformatf("lat3_ready_c%0d", k), 32'(rdy1), 32'(k == 0 || k >= 8));
            chk($sformatf("lat3_rvalid_c%0d", k), 32'(rv1), 32'(k >= 3 && k <= 10));
            if (k >= 3 && k <= 10) chk($sformatf("lat3_rdata_c%0d", k), rdata1, 32'h100 + 32'(k - 3));
        end

        // reset lands where beat 3 of an 8-beat write would be
        drive(1'b0, 1'b1, 1'b0, 2'd3, BASE, 32'h200);
        drive(1'b0, 1'b0, 1'b0, 2'd0, BASE, 32'h201);
        drive(1'b0, 1'b0, 1'b0, 2'd0, BASE, 32'h202);
        drive(1'b1, 1'b0, 1'b0, 2'd0, BASE, 32'h203);
        chk("rstmid_ready_in_rst", 32'(rdy0), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, BASE, 32'h204);
        chk("rstmid_ready_after", 32'(rdy0), 32'd1);
        chk("rstmid_busy_after", 32'(busy0), 32'd0);
        chk("rstmid_rvalid_after", 32'(rv0), 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 0) drive(1'b0, 1'b1, 1'b1, 2'd3, BASE, 32'h0);
            else idle();
            chk($sformatf("rstmid_rvalid_c%0d", k), 32'(rv0), 32'(k >= 1 && k <= 8));
            if (k >= 1 && k <= 8)
                chk($sformatf("rstmid_idx%0d", k - 1), rdata0, (k - 1 < 3) ? 32'h200 + 32'(k - 1) : 32'h100 + 32'(k - 1));
        end

        // reset while reads are still in the 3-deep pipeline drops them
        drive(1'b0, 1'b1, 1'b1, 2'd3, BASE, 32'h0);
        idle();
        drive(1'b1, 1'b0, 1'b1, 2'd0, BASE, 32'h0);
        for (int k = 0; k < 6; k++) begin
            idle();
            chk($sformatf("flush_rvalid_c%0d", k), 32'(rv1), 32'd0);
        end
        chk("flush_rdata", rdata1, 32'h0);
        chk("flush_ready", 32'(rdy1), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
